output_line_packer: RTL and testbench
=====================================

// Module: output_line_packer
// PURPOSE
//   Downstream stage of the streaming wrapper's processing units (PUs).
//   - Round-robin collects 32-bit output words from NUM_PU PU output streams.
//   - Packs them 16 per 512-bit line.
//   - Writes each line to memory as a single-beat write on the outputMem* channels.
//   - On end of stream, flushes a zero-padded partial line, then asserts finished.
// PARAMETERS
//   NUM_PU     4    number of PU output streams arbitrated (>=1)
//   LINE_BYTES 64   byte stride between consecutive lines (fixed 512-bit line)
// PORTS
//   clock               in   1        single clock, rising edge
//   reset               in   1        asynchronous, active-low (0 = reset)
//   base_addr           in   64       byte address of first output line
//   start               in   1        1-cycle pulse in IDLE: latch base_addr, begin
//   pu_word             in   32*NUM_PU  PU i word at [32i+31:32i]
//   pu_valid            in   NUM_PU   PU i word valid
//   pu_ready            out  NUM_PU   PU i word accepted this cycle
//   pu_done             in   NUM_PU   PU i will assert no further valid (sticky)
//   outputMemAddr       out  64       line write byte address
//   outputMemAddrValid  out  1        address valid
//   outputMemAddrLen    out  8        burst len-1, constant 0
//   outputMemAddrId     out  16       constant 0
//   outputMemAddrReady  in   1        address accepted
//   outputMemBlock      out  512      line data, word k at [32k+31:32k]
//   outputMemBlockValid out  1        data valid
//   outputMemBlockLast  out  1        equals outputMemBlockValid (single beat)
//   outputMemBlockReady in   1        data accepted
//   words_written       out  32       total PU words accepted (excl. padding)
//   finished            out  1        all lines written; sticky until reset
// BEHAVIOUR
//   - Reset state: all outputs 0. FSM in IDLE, line pointer 0, RR pointer 0.
//   - IDLE: waits for start; latches base_addr, goes to PACK.
//     A start seen in any other state is ignored.
//   - PACK grant: g = first i, scanning ptr, ptr+1, ... mod NUM_PU, with pu_valid[i].
//     - pu_ready[g] = 1 in the same cycle (combinational from pu_valid); no other ready.
//     - The word goes to slot word_cnt; word_cnt++; words_written++; ptr <= (g+1) mod NUM_PU.
//     - No valid: no grant, ptr unchanged.
//   - Line full: when the accept fills slot 15, next state is WRITE (flush=0).
//     pu_ready is all 0 outside PACK.
//   - End of stream: in PACK with &pu_done and no pu_valid:
//     - word_cnt>0: zero-fill unused slots, go to WRITE (flush=1).
//     - word_cnt==0: go to DONE.
//   - WRITE: outputMemAddrValid and outputMemBlockValid both rise on entry.
//     - outputMemAddr = base_addr + line_idx*LINE_BYTES (64-bit wrap, no check).
//     - Each valid drops the cycle after its own handshake; the two channels are independent.
//     - Both handshaken: line_idx++, word_cnt=0, buffer cleared; then DONE if flush, else PACK.
//     - Same-cycle handshakes on both channels finish WRITE in 1 cycle.
//     - Address and data held stable while valid.
//   - Latency: last word accepted -> both valids high on the next cycle.
//   - DONE: finished=1; all valids and readies 0; stays until reset.
//   - Reset mid-operation (async): immediate return to reset state.
//     Partially packed data and in-flight writes are dropped; no last beat is emitted.
//   - pu_done[i]=1 while pu_valid[i]=1: the word is still consumed; end of stream waits
//     for all valids low.
// CONFIGURATION
//   OUTPUT_PACKER_PERF_EN
//     - defined: adds out port stall_cycles[31:0] (reset 0). It counts cycles in WRITE
//       where any asserted valid is not ready, saturating at 0xFFFFFFFF.
//     - undefined: port absent, no counter logic.
// TESTING
//   1 NUM_PU=1, base 0x1000, PU0 sends 0..15 back-to-back, ready=1
//     -> one write, addr 0x1000, block word k = k, Last=1, words_written=16.
//   2 NUM_PU=4, all PUs valid continuously, PU i sends i*100+n
//     -> grant order 0,1,2,3,0..; line0 word0=0, word1=100, word2=200, word3=300, word4=1.
//   3 PU0 sends 20 words, then pu_done=all
//     -> 2 writes at base, base+64; line1 words 0-3 = words 16-19, words 4-15 = 0;
//        finished=1; words_written=20.
//   4 outputMemAddrReady held 0 for 5 cycles, BlockReady=1
//     -> data valid drops after 1 cycle, addr valid stays 5 cycles, pu_ready=0 throughout;
//        PACK resumes after the addr handshake.
//   5 reset pulled low while in WRITE with 7 words packed
//     -> outputs 0 immediately; after start, first line written at the new base with fresh data.
//   6 start, then pu_done=all with no words
//     -> no memory traffic; finished=1 two cycles after start.

Source files
------------

// File: rtl/output_line_packer.sv
// Round-robin packs 32-bit PU words 16 per 512-bit line, one-beat line writes; last accept -> valids next cycle, PACK stalls (pu_ready=0) until both channels handshake.
// Optional OUTPUT_PACKER_PERF_EN adds stall_cycles: WRITE cycles with an asserted valid not ready (saturating).
module output_line_packer #(
  parameter int NUM_PU     = 4,
  parameter int LINE_BYTES = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [63:0]          base_addr,
  input  logic                 start,
  input  logic [32*NUM_PU-1:0] pu_word,
  input  logic [NUM_PU-1:0]    pu_valid,
  output logic [NUM_PU-1:0]    pu_ready,
  input  logic [NUM_PU-1:0]    pu_done,
  output logic [63:0]          outputMemAddr,
  output logic                 outputMemAddrValid,
  output logic [7:0]           outputMemAddrLen,
  output logic [15:0]          outputMemAddrId,
  input  logic                 outputMemAddrReady,
  output logic [511:0]         outputMemBlock,
  output logic                 outputMemBlockValid,
  output logic                 outputMemBlockLast,
  input  logic                 outputMemBlockReady,
  output logic [31:0]          words_written,
  output logic                 finished
`ifdef OUTPUT_PACKER_PERF_EN
  ,
  output logic [31:0]          stall_cycles
`endif
);

  localparam int PTR_W = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;
  localparam logic [63:0] LINE_STRIDE = 64'(LINE_BYTES);

  typedef enum logic [1:0] {IDLE, PACK, WRITE, DONE} state_t;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   cand;
  logic               gnt_vld;
  logic [31:0]        gnt_word;
  logic [3:0]         word_cnt;
  logic [511:0]       buffer;
  logic [63:0]        base_q;
  logic [63:0]        line_idx;
  logic               flush;
  logic               write_done;

  // First valid PU at or after the round-robin pointer wins.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    cand     = '0;
    gnt_word = '0;
    pu_ready = '0;
    if (state == PACK) begin
      for (int i = 0; i < NUM_PU; i++) begin
        cand = PTR_W'((int'(ptr) + i) % NUM_PU);
        if (!gnt_vld && pu_valid[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    for (int i = 0; i < NUM_PU; i++) begin
      if (gnt_vld && int'(gnt_idx) == i) begin
        pu_ready[i] = 1'b1;
        gnt_word    = pu_word[32*i +: 32];
      end
    end
  end

  assign ptr_nxt    = (int'(gnt_idx) == NUM_PU - 1) ? '0 : gnt_idx + 1'b1;
  assign write_done = (!outputMemAddrValid || outputMemAddrReady) &&
                      (!outputMemBlockValid || outputMemBlockReady);

  assign outputMemAddrLen   = 8'd0;
  assign outputMemAddrId    = 16'd0;
  assign outputMemBlock     = buffer;
  assign outputMemBlockLast = outputMemBlockValid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      ptr                 <= '0;
      word_cnt            <= 4'd0;
      buffer              <= '0;
      base_q              <= 64'd0;
      line_idx            <= 64'd0;
      flush               <= 1'b0;
      outputMemAddr       <= 64'd0;
      outputMemAddrValid  <= 1'b0;
      outputMemBlockValid <= 1'b0;
      words_written       <= 32'd0;
      finished            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q <= base_addr;
            state  <= PACK;
          end
        end
        PACK: begin
          if (gnt_vld) begin
            for (int k = 0; k < 16; k++) begin
              if (word_cnt == 4'(k)) buffer[32*k +: 32] <= gnt_word;
            end
            word_cnt      <= word_cnt + 4'd1;
            words_written <= words_written + 32'd1;
            ptr           <= ptr_nxt;
            if (word_cnt == 4'd15) begin
              flush               <= 1'b0;
              state               <= WRITE;
              outputMemAddr       <= base_q + line_idx * LINE_STRIDE;
              outputMemAddrValid  <= 1'b1;
              outputMemBlockValid <= 1'b1;
            end
          end else if (&pu_done) begin
            // Unused slots are already zero: the buffer is cleared after every line.
            if (word_cnt != 4'd0) begin
              flush               <= 1'b1;
              state               <= WRITE;
              outputMemAddr       <= base_q + line_idx * LINE_STRIDE;
              outputMemAddrValid  <= 1'b1;
              outputMemBlockValid <= 1'b1;
            end else begin
              state    <= DONE;
              finished <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (outputMemAddrValid && outputMemAddrReady)   outputMemAddrValid  <= 1'b0;
          if (outputMemBlockValid && outputMemBlockReady) outputMemBlockValid <= 1'b0;
          if (write_done) begin
            line_idx <= line_idx + 64'd1;
            word_cnt <= 4'd0;
            buffer   <= '0;
            if (flush) begin
              state    <= DONE;
              finished <= 1'b1;
            end else begin
              state <= PACK;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef OUTPUT_PACKER_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles <= 32'd0;
    end else if (state == WRITE &&
                 ((outputMemAddrValid && !outputMemAddrReady) ||
                  (outputMemBlockValid && !outputMemBlockReady)) &&
                 stall_cycles != 32'hFFFF_FFFF) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_output_line_packer.sv
// Directed bench: a 1-PU instance for the single-stream line and a 4-PU instance for arbitration, flush, backpressure, reset and empty-stream cases.
module tb_output_line_packer;

  logic         clock;
  logic         reset;

  // 4-PU instance
  logic [63:0]  base_addr;
  logic         start;
  logic [127:0] pu_word;
  logic [3:0]   pu_valid;
  logic [3:0]   pu_ready;
  logic [3:0]   pu_done;
  logic [63:0]  oma;
  logic         oma_vld;
  logic [7:0]   oma_len;
  logic [15:0]  oma_id;
  logic         oma_rdy;
  logic [511:0] omb;
  logic         omb_vld;
  logic         omb_last;
  logic         omb_rdy;
  logic [31:0]  words_written;
  logic         finished;
  logic [31:0]  stall_cycles;

  // 1-PU instance
  logic [63:0]  u1_base;
  logic         u1_start;
  logic [31:0]  u1_word;
  logic [0:0]   u1_valid;
  logic [0:0]   u1_ready;
  logic [0:0]   u1_done;
  logic [63:0]  u1_oma;
  logic         u1_oma_vld;
  logic [7:0]   u1_oma_len;
  logic [15:0]  u1_oma_id;
  logic         u1_oma_rdy;
  logic [511:0] u1_omb;
  logic         u1_omb_vld;
  logic         u1_omb_last;
  logic         u1_omb_rdy;
  logic [31:0]  u1_ww;
  logic         u1_finished;
  logic [31:0]  u1_stall;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0]  addr_q[$];
  logic [511:0] blk_q[$];
  logic         last_q[$];
  logic [63:0]  u1_addr_q[$];
  logic [511:0] u1_blk_q[$];
  logic         u1_last_q[$];

  output_line_packer #(.NUM_PU(4), .LINE_BYTES(64)) dut (
    .clock(clock), .reset(reset), .base_addr(base_addr), .start(start),
    .pu_word(pu_word), .pu_valid(pu_valid), .pu_ready(pu_ready), .pu_done(pu_done),
    .outputMemAddr(oma), .outputMemAddrValid(oma_vld), .outputMemAddrLen(oma_len),
    .outputMemAddrId(oma_id), .outputMemAddrReady(oma_rdy),
    .outputMemBlock(omb), .outputMemBlockValid(omb_vld), .outputMemBlockLast(omb_last),
    .outputMemBlockReady(omb_rdy), .words_written(words_written), .finished(finished)
`ifdef OUTPUT_PACKER_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  output_line_packer #(.NUM_PU(1), .LINE_BYTES(64)) dut1 (
    .clock(clock), .reset(reset), .base_addr(u1_base), .start(u1_start),
    .pu_word(u1_word), .pu_valid(u1_valid), .pu_ready(u1_ready), .pu_done(u1_done),
    .outputMemAddr(u1_oma), .outputMemAddrValid(u1_oma_vld), .outputMemAddrLen(u1_oma_len),
    .outputMemAddrId(u1_oma_id), .outputMemAddrReady(u1_oma_rdy),
    .outputMemBlock(u1_omb), .outputMemBlockValid(u1_omb_vld), .outputMemBlockLast(u1_omb_last),
    .outputMemBlockReady(u1_omb_rdy), .words_written(u1_ww), .finished(u1_finished)
`ifdef OUTPUT_PACKER_PERF_EN
    , .stall_cycles(u1_stall)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change at posedge+1, so a valid&ready seen at negedge is a handshake at the next edge.
  always @(negedge clock) begin
    if (oma_vld && oma_rdy) addr_q.push_back(oma);
    if (omb_vld && omb_rdy) begin
      blk_q.push_back(omb);
      last_q.push_back(omb_last);
    end
    if (u1_oma_vld && u1_oma_rdy) u1_addr_q.push_back(u1_oma);
    if (u1_omb_vld && u1_omb_rdy) begin
      u1_blk_q.push_back(u1_omb);
      u1_last_q.push_back(u1_omb_last);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    start     = 1'b0;
    base_addr = 64'd0;
    pu_word   = '0;
    pu_valid  = '0;
    pu_done   = '0;
    oma_rdy   = 1'b1;
    omb_rdy   = 1'b1;
    repeat (3) tick();
    addr_q.delete();
    blk_q.delete();
    last_q.delete();
    reset = 1'b1;
    tick();
  endtask

  task automatic start_run(input logic [63:0] b);
    base_addr = b;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Offers n words from PU p (values v0, v0+1, ...), retrying while not accepted.
  task automatic feed(input int p, input int n, input logic [31:0] v0);
    int  acc = 0;
    int  guard = 0;
    logic took;
    while (acc < n && guard < 200) begin
      pu_valid          = '0;
      pu_valid[p]       = 1'b1;
      pu_word[32*p +: 32] = v0 + 32'(acc);
      @(negedge clock);
      took = pu_ready[p];
      tick();
      if (took) acc++;
      guard++;
    end
    pu_valid = '0;
    check("feed_count", 64'(acc), 64'(n));
  endtask

  task automatic wait_writes(input int n, input string tag);
    int g = 0;
    while ((blk_q.size() < n || addr_q.size() < n) && g < 100) begin
      tick();
      g++;
    end
    check(tag, 64'(blk_q.size()), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] b;
    int cnt[4];
    int g;
    int gg;

    u1_base = 64'd0; u1_start = 1'b0; u1_word = '0; u1_valid = '0; u1_done = '0;
    u1_oma_rdy = 1'b1; u1_omb_rdy = 1'b1;
    reset = 1'b0; start = 1'b0; base_addr = 64'd0; pu_word = '0; pu_valid = '0;
    pu_done = '0; oma_rdy = 1'b1; omb_rdy = 1'b1;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_addr_vld", 64'(oma_vld), 64'd0);
    check("rst_blk_vld", 64'(omb_vld), 64'd0);
    check("rst_last", 64'(omb_last), 64'd0);
    check("rst_addr", oma, 64'd0);
    check("rst_blk_nz", 64'(|omb), 64'd0);
    check("rst_ww", 64'(words_written), 64'd0);
    check("rst_finished", 64'(finished), 64'd0);
    check("rst_ready", 64'(pu_ready), 64'd0);
    check("rst_u1_finished", 64'(u1_finished), 64'd0);
    tick();
    reset = 1'b1;
    tick();

    // 1: single PU, 16 back-to-back words
    u1_base = 64'h1000;
    u1_start = 1'b1;
    tick();
    u1_start = 1'b0;
    for (int n = 0; n < 16; n++) begin
      u1_valid = 1'b1;
      u1_word  = 32'(n);
      @(negedge clock);
      if (n == 0 || n == 15) check($sformatf("t1_ready%0d", n), 64'(u1_ready), 64'd1);
      tick();
    end
    u1_valid = 1'b0;
    @(negedge clock);
    check("t1_lat_addr_vld", 64'(u1_oma_vld), 64'd1);
    check("t1_lat_blk_vld", 64'(u1_omb_vld), 64'd1);
    begin
      int w = 0;
      while (u1_blk_q.size() < 1 && w < 50) begin tick(); w++; end
    end
    check("t1_writes", 64'(u1_blk_q.size()), 64'd1);
    if (u1_blk_q.size() >= 1 && u1_addr_q.size() >= 1) begin
      check("t1_addr", u1_addr_q[0], 64'h1000);
      check("t1_last", 64'(u1_last_q[0]), 64'd1);
      b = u1_blk_q[0];
      for (int k = 0; k < 16; k++) check($sformatf("t1_word%0d", k), 64'(b[32*k +: 32]), 64'(k));
    end
    check("t1_ww", 64'(u1_ww), 64'd16);

    // 2: four PUs continuously valid, round-robin order
    do_reset();
    start_run(64'h2000);
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int k = 0; k < 16; k++) begin
      pu_valid = 4'hF;
      for (int i = 0; i < 4; i++) pu_word[32*i +: 32] = 32'(i * 100 + cnt[i]);
      @(negedge clock);
      g = -1;
      gg = 0;
      for (int i = 0; i < 4; i++) if (pu_ready[i]) begin g = i; gg++; end
      check($sformatf("t2_grant%0d", k), 64'(g), 64'(k % 4));
      if (gg != 1) check("t2_onehot", 64'(gg), 64'd1);
      tick();
      if (g >= 0) cnt[g]++;
    end
    pu_valid = '0;
    wait_writes(1, "t2_writes");
    if (blk_q.size() >= 1) begin
      check("t2_addr", addr_q[0], 64'h2000);
      b = blk_q[0];
      for (int k = 0; k < 16; k++)
        check($sformatf("t2_word%0d", k), 64'(b[32*k +: 32]), 64'((k % 4) * 100 + k / 4));
    end
    check("t2_ww", 64'(words_written), 64'd16);

    // 3: 20 words from PU0, then end of stream flushes a padded line
    do_reset();
    start_run(64'h3000);
    feed(0, 20, 32'hA000);
    pu_done = 4'hF;
    begin
      int w = 0;
      while (!finished && w < 50) begin tick(); w++; end
    end
    @(negedge clock);
    check("t3_finished", 64'(finished), 64'd1);
    check("t3_writes", 64'(blk_q.size()), 64'd2);
    if (blk_q.size() >= 2 && addr_q.size() >= 2) begin
      check("t3_addr0", addr_q[0], 64'h3000);
      check("t3_addr1", addr_q[1], 64'h3040);
      check("t3_last1", 64'(last_q[1]), 64'd1);
      b = blk_q[1];
      for (int k = 0; k < 4; k++)
        check($sformatf("t3_l1w%0d", k), 64'(b[32*k +: 32]), 64'(32'hA010 + 32'(k)));
      check("t3_pad_nz", 64'(|b[511:128]), 64'd0);
    end
    check("t3_ww", 64'(words_written), 64'd20);
    check("t3_done_vld", 64'({oma_vld, omb_vld, pu_ready}), 64'd0);

    // 4: address channel stalled 5 cycles, data channel ready
    do_reset();
    oma_rdy = 1'b0;
    start_run(64'h4000);
    feed(1, 16, 32'hB000);
    pu_valid = 4'b0010;
    pu_word[63:32] = 32'hBEEF;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      check($sformatf("t4_addr_vld_c%0d", c), 64'(oma_vld), 64'd1);
      check($sformatf("t4_blk_vld_c%0d", c), 64'(omb_vld), (c == 1) ? 64'd1 : 64'd0);
      check($sformatf("t4_ready_c%0d", c), 64'(pu_ready), 64'd0);
      tick();
    end
    oma_rdy = 1'b1;
    @(negedge clock);
    check("t4_addr_vld_c6", 64'(oma_vld), 64'd1);
    tick();
    @(negedge clock);
    check("t4_resume_ready", 64'(pu_ready), 64'b0010);
    check("t4_addr_vld_c7", 64'(oma_vld), 64'd0);
    tick();
    pu_valid = '0;
    check("t4_writes", 64'(blk_q.size()), 64'd1);
    if (blk_q.size() >= 1 && addr_q.size() >= 1) begin
      check("t4_addr", addr_q[0], 64'h4000);
      b = blk_q[0];
      check("t4_word0", 64'(b[31:0]), 64'hB000);
    end
`ifdef OUTPUT_PACKER_PERF_EN
    check("t4_stall_cycles", 64'(stall_cycles), 64'd5);
`endif

    // 5: reset while a 7-word flush line is waiting in WRITE
    oma_rdy = 1'b0;
    omb_rdy = 1'b0;
    feed(0, 6, 32'hD000);
    pu_done = 4'hF;
    repeat (2) tick();
    @(negedge clock);
    check("t5_wr_addr_vld", 64'(oma_vld), 64'd1);
    check("t5_wr_blk_vld", 64'(omb_vld), 64'd1);
    check("t5_ww", 64'(words_written), 64'd23);
    tick();
    reset = 1'b0;
    #1;
    check("t5_rst_addr_vld", 64'(oma_vld), 64'd0);
    check("t5_rst_blk_vld", 64'(omb_vld), 64'd0);
    check("t5_rst_ww", 64'(words_written), 64'd0);
    check("t5_rst_blk_nz", 64'(|omb), 64'd0);
    check("t5_rst_addr", oma, 64'd0);
    do_reset();
    start_run(64'h5000);
    feed(2, 16, 32'hC000);
    wait_writes(1, "t5_writes");
    if (blk_q.size() >= 1 && addr_q.size() >= 1) begin
      check("t5_addr", addr_q[0], 64'h5000);
      b = blk_q[0];
      check("t5_word0", 64'(b[31:0]), 64'hC000);
      check("t5_word6", 64'(b[223:192]), 64'hC006);
      check("t5_word15", 64'(b[511:480]), 64'hC00F);
    end

    // 6: empty stream finishes two cycles after start
    do_reset();
    base_addr = 64'h6000;
    start     = 1'b1;
    pu_done   = 4'hF;
    tick();
    start = 1'b0;
    @(negedge clock);
    check("t6_fin_c1", 64'(finished), 64'd0);
    tick();
    @(negedge clock);
    check("t6_fin_c2", 64'(finished), 64'd1);
    check("t6_vld", 64'({oma_vld, omb_vld}), 64'd0);
    repeat (3) tick();
    check("t6_no_traffic", 64'(addr_q.size() + blk_q.size()), 64'd0);
    check("t6_ww", 64'(words_written), 64'd0);
    check("t6_fin_sticky", 64'(finished), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
